ysyx_22050854_wb_arbiter: RTL and testbench
===========================================

YSYX_22050854_WB_ARBITER -- requirements
Module: ysyx_22050854_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, register data width.
REQ-002 Parameter LQ_DEPTH, default 2, load-result queue depth (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 iss_valid  input  1  decoder issues an instruction this cycle.
REQ-006 iss_wen  input  1  issued instruction writes rd.
REQ-007 iss_rd  input  5  destination register of issued instruction.
REQ-008 chk_rs1, chk_rs2  input  5 each  source registers to hazard-check.
REQ-009 hazard  output  1  combinational: busy[chk_rs1] | busy[chk_rs2].
REQ-010 alu_valid, alu_rd[5], alu_data[XLEN]  input  ALU result; no ready, always accepted.
REQ-011 lsu_valid, lsu_rd[5], lsu_data[XLEN]  input  load result; transfers when lsu_valid & lsu_ready.
REQ-012 lsu_ready  output  1  queue not full (registered count, no combinational path from lsu_valid).
REQ-013 flush  input  1  squash all pending writebacks and reservations.
REQ-014 rf_wen, rf_waddr[5], rf_wdata[XLEN]  output  registered register-file write port.
REQ-015 rf_wresp  input  1  register-file write acknowledge, valid one cycle after rf_wen.
REQ-016 resp_err  output  1  sticky: rf_wen seen with no rf_wresp the following cycle.

Function
REQ-017 Output stage: rf_wen/rf_waddr/rf_wdata SHALL be registered; source accepted in cycle N appears on the port in cycle N+1.
REQ-018 Priority: ALU result SHALL win; queue head drains only in cycles with alu_valid=0.
REQ-019 Load path: accepted lsu results SHALL be written into the FIFO; same-cycle push and pop allowed, including when full (pop frees the slot next cycle only; lsu_ready uses registered count).
REQ-020 Load bypass: queue empty, alu_valid=0 and lsu handshake in cycle N SHALL still go through the queue (rf_wen at N+2); no bypass path.
REQ-021 rd=0: results with rd=0 SHALL be consumed but SHALL NOT assert rf_wen.
REQ-022 Scoreboard: 32-bit busy vector; iss_valid & iss_wen & iss_rd!=0 sets busy[iss_rd].
REQ-023 busy[rf_waddr] SHALL clear at the clock edge ending a cycle with rf_wen=1.
REQ-024 Simultaneous set and clear of the same register SHALL leave it busy (set wins).
REQ-025 busy[0] SHALL always read 0.
REQ-026 Flush cycle: FIFO emptied, busy cleared, any alu/lsu input in that cycle dropped, rf_wen=0 next cycle; iss_* in a flush cycle ignored.
REQ-027 resp_err SHALL set when rf_wen=1 in cycle N and rf_wresp=0 in N+1, and stay set until reset.
REQ-028 LSU data SHALL be held stable by source while lsu_valid & !lsu_ready (checked by bench, not block).

Reset
REQ-029 On rst: rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty, lsu_ready=1 after release, resp_err=0, hazard=0.
REQ-030 rst asserted mid-operation SHALL discard queued and in-flight results immediately, without waiting for clk.

Structure
REQ-031 Package ysyx_22050854_pkg SHALL hold XLEN, REG_ADDR_W=5, NUM_REGS=32 and the writeback-entry struct {rd, data}.
REQ-032 Queue SHALL be sub-module ysyx_22050854_wb_fifo (push/pop/full/empty/count, flush, async reset).
REQ-033 Target size 150-300 lines RTL total.

Verification
REQ-034 ALU only: alu_valid=1, rd=5, data=0x1234 at cycle 3 -> rf_wen=1, waddr=5, wdata=0x1234 at cycle 4; busy[5] (set by issue at cycle 1) clear from cycle 5.
REQ-035 Conflict: alu rd=3 and lsu rd=4 both valid at cycle 10 -> writes x3 at cycle 11, x4 at cycle 12.
REQ-036 Backpressure: alu_valid=1 for 6 cycles, lsu streams 3 results -> lsu_ready=0 after 2 accepted, third held; all three written in order after ALU stops, none lost.
REQ-037 Hazard: issue rd=7, check rs1=7 -> hazard=1 until edge after rf_wen for x7; same-cycle reissue of rd=7 keeps hazard=1.
REQ-038 rd=0 and flush: alu rd=0 -> rf_wen stays 0; 2 queued loads plus flush -> no rf_wen, busy=0, lsu_ready=1.
REQ-039 Response check: hold rf_wresp=0 after a write -> resp_err=1 next cycle, remains 1 until rst.

Source files
------------

// File: rtl/ysyx_22050854_pkg.sv
// Shared widths and the writeback-entry record for the writeback arbiter.
// No logic here; widths only.
// No flow control here; consumers define their own.
package ysyx_22050854_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/ysyx_22050854_wb_fifo.sv
// Small circular queue holding load results waiting for a writeback slot.
// Latency: a pushed entry is visible at dout one cycle after the push edge.
// Backpressure: full comes from the registered count; push while full and pop while empty are ignored.
module ysyx_22050854_wb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; flush and reset both drop every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage array; contents are don't-care whenever the count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/ysyx_22050854_wb_arbiter.sv
// Merges ALU and load results onto one registered register-file write port and tracks busy registers.
// Latency: ALU result to rf_wen is 1 cycle; load result to rf_wen is at least 2 cycles (always queued).
// Backpressure: ALU is never stalled; loads stall via lsu_ready, driven only by the registered queue count.
module ysyx_22050854_wb_arbiter
    import ysyx_22050854_pkg::*;
#(
    parameter int XLEN     = ysyx_22050854_pkg::XLEN,
    parameter int LQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic                  iss_wen,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  hazard,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    input  logic                  flush,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic                  rf_wresp,
    output logic                  resp_err
);
    localparam int EW = REG_ADDR_W + XLEN;
    localparam int CW = $clog2(LQ_DEPTH) + 1;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_full;
    logic                  q_empty;
    logic [EW-1:0]         q_dout;
    logic [CW-1:0]         q_count_unused;
    logic [REG_ADDR_W-1:0] q_rd;
    logic [XLEN-1:0]       q_data;
    logic                  wen_q;

    // Loads always pass through the queue; the head drains only when the ALU leaves the port idle.
    assign lsu_ready = ~q_full;
    assign q_push    = lsu_valid & lsu_ready & ~flush;
    assign q_pop     = ~alu_valid & ~q_empty & ~flush;
    assign q_rd      = q_dout[EW-1 -: REG_ADDR_W];
    assign q_data    = q_dout[XLEN-1:0];

    ysyx_22050854_wb_fifo #(
        .W     (EW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (q_push),
        .din   ({lsu_rd, lsu_data}),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count_unused)
    );

    // Registered write port: ALU wins, otherwise queue head; rd=0 results are consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (flush) begin
            rf_wen   <= 1'b0;
        end else if (alu_valid) begin
            rf_wen   <= (alu_rd != '0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (q_pop) begin
            rf_wen   <= (q_rd != '0);
            rf_waddr <= q_rd;
            rf_wdata <= q_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Next busy vector: completed write clears, issue sets afterwards so a same-cycle reissue stays busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
        if (iss_valid && iss_wen && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; a flush drops every outstanding reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        busy <= '0;
        else if (flush) busy <= '0;
        else            busy <= busy_nxt;
    end

    assign hazard = busy[chk_rs1] | busy[chk_rs2];

    // Sticky error when the register file fails to acknowledge the cycle after a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q    <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            wen_q <= rf_wen;
            if (wen_q && !rf_wresp) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
module tb_ysyx_22050854_wb_arbiter;
    import ysyx_22050854_pkg::*;

    localparam int XL    = 64;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid, iss_wen;
    logic [4:0]    iss_rd, chk_rs1, chk_rs2;
    logic          hazard;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [XL-1:0] alu_data;
    logic          lsu_valid;
    logic [4:0]    lsu_rd;
    logic [XL-1:0] lsu_data;
    logic          lsu_ready;
    logic          flush;
    logic          rf_wen;
    logic [4:0]    rf_waddr;
    logic [XL-1:0] rf_wdata;
    logic          rf_wresp;
    logic          resp_err;

    ysyx_22050854_wb_arbiter #(.XLEN(XL), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .flush(flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wresp(rf_wresp), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of pending loads + busy set ----------------
    wb_entry_t mq[$];
    bit [31:0] mbusy;
    bit        m_wen, m_pend, m_err;
    logic [4:0]    m_waddr;
    logic [XL-1:0] m_wdata;

    task automatic model_reset();
        mq.delete();
        mbusy = '0; m_wen = 0; m_pend = 0; m_err = 0;
        m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_compare();
        bit exp_hz;
        exp_hz = (chk_rs1 != 0 && mbusy[chk_rs1]) || (chk_rs2 != 0 && mbusy[chk_rs2]);
        chk("m_rf_wen", rf_wen, m_wen);
        if (m_wen) begin
            chk("m_rf_waddr", rf_waddr, m_waddr);
            chk("m_rf_wdata", rf_wdata, m_wdata);
        end
        chk("m_hazard", hazard, exp_hz);
        chk("m_lsu_ready", lsu_ready, mq.size() < DEPTH);
        chk("m_resp_err", resp_err, m_err);
    endtask

    task automatic model_step();
        bit rdy;
        wb_entry_t e;
        rdy = (mq.size() < DEPTH);
        m_err  = m_err | (m_pend & !rf_wresp);
        m_pend = m_wen;
        if (flush) begin
            mq.delete();
            mbusy = '0;
            m_wen = 0;
        end else begin
            if (m_wen) mbusy[m_waddr] = 0;
            if (iss_valid && iss_wen && iss_rd != 0) mbusy[iss_rd] = 1;
            if (alu_valid) begin
                m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wen = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data;
            end else begin
                m_wen = 0;
            end
            if (lsu_valid && rdy) begin
                e.rd = lsu_rd; e.data = lsu_data;
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- cycle helpers ----------------
    bit resp_en = 1;
    bit cyc_wen;
    bit hs;

    task automatic half_check();
        @(negedge clk);
        model_compare();
        cyc_wen = rf_wen;
        hs = lsu_valid & lsu_ready;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
        rf_wresp = resp_en & cyc_wen;
    endtask

    task automatic tick();
        half_check();
        edge_step();
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_wen = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = '0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = '0; flush = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit iv; logic [4:0] ird; logic [4:0] rs1; logic [4:0] rs2;
        bit av; logic [4:0] ard; logic [63:0] ad;
        bit lv; logic [4:0] lrd; logic [63:0] ld;
        bit e_wen; logic [4:0] e_waddr; logic [63:0] e_wdata; bit e_hz; bit e_rdy;
    } vec_t;

    function automatic vec_t mk(bit iv, int ird, int rs1, int rs2, bit av, int ard, logic [63:0] ad,
                                bit lv, int lrd, logic [63:0] ld, bit ew, int ea, logic [63:0] ed,
                                bit hz, bit rdy);
        vec_t v;
        v.iv = iv; v.ird = 5'(ird); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.av = av; v.ard = 5'(ard); v.ad = ad;
        v.lv = lv; v.lrd = 5'(lrd); v.ld = ld;
        v.e_wen = ew; v.e_waddr = 5'(ea); v.e_wdata = ed; v.e_hz = hz; v.e_rdy = rdy;
        return v;
    endfunction

    vec_t tbl[$];
    logic [4:0]  exp_a[$];
    logic [63:0] exp_d[$];
    logic [4:0]  obs_a[$];
    logic [63:0] obs_d[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rf_wresp = 0;
        rst = 0;
        #1 rst = 1;
        #2;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_resp_err", resp_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        half_check();
        chk("rst_lsu_ready", lsu_ready, 1);
        edge_step();

        //        iv ird rs1 rs2 av ard ad       lv lrd ld      wen a  data     hz rdy
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(1, 5, 5, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 5, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1));
        tbl.push_back(mk(0, 0, 5, 0, 1, 5, 'h1234,  0, 0, 0,       0, 0, 0,       1, 1));
        tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0,       0, 0, 0,       1, 5, 'h1234,  1, 1));
        tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(1, 7, 7, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 7, 0, 1, 7, 'h77,    0, 0, 0,       0, 0, 0,       1, 1));
        tbl.push_back(mk(1, 7, 7, 0, 0, 0, 0,       0, 0, 0,       1, 7, 'h77,    1, 1));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1));
        tbl.push_back(mk(0, 0, 7, 0, 1, 7, 'h78,    0, 0, 0,       0, 0, 0,       1, 1));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0,       0, 0, 0,       1, 7, 'h78,    1, 1));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 'h33,    1, 4, 'h44,    0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 3, 'h33,    0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 4, 'h44,    0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h99,    0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       1, 9, 'h99,    0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 9, 'h99,    0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       1, 0, 'h5,     0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 1));

        foreach (tbl[i]) begin
            iss_valid = tbl[i].iv; iss_wen = tbl[i].iv; iss_rd = tbl[i].ird;
            chk_rs1 = tbl[i].rs1; chk_rs2 = tbl[i].rs2;
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            flush = 0;
            half_check();
            chk($sformatf("tbl%0d_wen", i), rf_wen, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].e_waddr);
                chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wdata);
            end
            chk($sformatf("tbl%0d_hazard", i), hazard, tbl[i].e_hz);
            chk($sformatf("tbl%0d_ready", i), lsu_ready, tbl[i].e_rdy);
            edge_step();
        end
        idle_inputs();

        // ---- backpressure: 6 ALU cycles while three loads stream in ----
        begin
            int li;
            logic [4:0]  ld_rd[3];
            logic [63:0] ld_dt[3];
            ld_rd[0] = 20; ld_dt[0] = 'hA0;
            ld_rd[1] = 21; ld_dt[1] = 'hB1;
            ld_rd[2] = 22; ld_dt[2] = 'hC2;
            li = 0;
            obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
            for (int c = 0; c < 6; c++) begin
                exp_a.push_back(5'(10 + c)); exp_d.push_back(64'(256 + c));
            end
            for (int k = 0; k < 3; k++) begin
                exp_a.push_back(ld_rd[k]); exp_d.push_back(ld_dt[k]);
            end
            for (int c = 0; c < 13; c++) begin
                alu_valid = (c < 6); alu_rd = 5'(10 + c); alu_data = 64'(256 + c);
                lsu_valid = (li < 3);
                lsu_rd = (li < 3) ? ld_rd[li] : 5'd0;
                lsu_data = (li < 3) ? ld_dt[li] : 64'd0;
                half_check();
                if (c == 2) chk("bp_ready_low_when_full", lsu_ready, 0);
                if (c == 6) chk("bp_accepted_during_alu", li, 2);
                if (rf_wen) begin
                    obs_a.push_back(rf_waddr); obs_d.push_back(rf_wdata);
                end
                edge_step();
                if (hs) li++;
            end
            chk("bp_all_accepted", li, 3);
            chk("bp_write_count", obs_a.size(), exp_a.size());
            for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
                chk($sformatf("bp_order_addr%0d", k), obs_a[k], exp_a[k]);
                chk($sformatf("bp_order_data%0d", k), obs_d[k], exp_d[k]);
            end
        end
        idle_inputs();

        // ---- flush with two queued loads and live reservations ----
        iss_valid = 1; iss_wen = 1; iss_rd = 11;
        alu_valid = 1; alu_rd = 1; alu_data = 'h1;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 'hB0;
        tick();
        iss_rd = 12; alu_rd = 2; alu_data = 'h2; lsu_rd = 12; lsu_data = 'hC0;
        tick();
        iss_rd = 14; alu_rd = 3; alu_data = 'h3; lsu_valid = 0; flush = 1;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk_rs1 = (c == 1) ? 5'd14 : 5'd11; chk_rs2 = 12;
            half_check();
            chk("flush_no_wen", rf_wen, 0);
            chk("flush_busy_clear", hazard, 0);
            chk("flush_ready", lsu_ready, 1);
            edge_step();
        end
        idle_inputs();

        // ---- missing write response ----
        resp_en = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 'h5;
        tick();
        idle_inputs();
        half_check(); chk("resp_wen", rf_wen, 1); edge_step();
        half_check(); chk("resp_err_not_yet", resp_err, 0); edge_step();
        resp_en = 1;
        for (int c = 0; c < 4; c++) begin
            alu_valid = (c == 1); alu_rd = 2; alu_data = 'h6;
            half_check(); chk("resp_err_sticky", resp_err, 1); edge_step();
        end
        idle_inputs();

        // ---- asynchronous reset in the middle of traffic ----
        iss_valid = 1; iss_wen = 1; iss_rd = 6; chk_rs1 = 6;
        tick();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 6; alu_data = 'h66;
        lsu_valid = 1; lsu_rd = 8; lsu_data = 'h88;
        tick();
        idle_inputs(); chk_rs1 = 6;
        half_check();
        chk("pre_arst_wen", rf_wen, 1);
        #2 rst = 1;
        #1;
        chk("arst_rf_wen", rf_wen, 0);
        chk("arst_rf_waddr", rf_waddr, 0);
        chk("arst_rf_wdata", rf_wdata, 0);
        chk("arst_hazard", hazard, 0);
        chk("arst_resp_err", resp_err, 0);
        chk("arst_lsu_ready", lsu_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        rf_wresp = 0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            half_check(); chk("arst_queue_dropped", rf_wen, 0); edge_step();
        end

        // ---- randomized traffic against the model ----
        hs = 1;
        for (int i = 0; i < 400; i++) begin
            if (hs || !lsu_valid) begin
                lsu_valid = ($urandom_range(0, 99) < 50);
                lsu_rd = 5'($urandom_range(0, 7));
                lsu_data = {$urandom, $urandom};
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_wen = ($urandom_range(0, 3) != 0);
            iss_rd = 5'($urandom_range(0, 7));
            chk_rs1 = 5'($urandom_range(0, 7));
            chk_rs2 = 5'($urandom_range(0, 7));
            alu_valid = ($urandom_range(0, 99) < 40);
            alu_rd = 5'($urandom_range(0, 7));
            alu_data = {$urandom, $urandom};
            flush = ($urandom_range(0, 99) < 3);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
